memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 178 +++++++++++++++++
 tb/tb_memory_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Memory stage of a Y86-64 style pipeline: the M pipeline register plus an
// 8-byte little-endian data memory with combinational read and clocked write.
//
// Optional build macro MEM_BOUNDS_CHECK_EN: when defined, an access is valid
// only if the whole 8-byte word lies inside the memory. Out-of-range accesses
// raise ADR and never write. When undefined, every address is valid and byte
// indices wrap modulo MEM_BYTES.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   M_stall, M_bubble   M register hold / NOP-insert (stall wins)
//   e_stat, E_Ins_Code, e_Cnd, e_Value_E, E_Value_A, e_dstE, E_dstM
//                       execute-stage values captured into the M register
//   M_stat .. M_dstM    registered M register contents
//   m_stat              memory-stage status (combinational)
//   m_Value_M           memory read data (combinational, 0 when not a read)
module memory_stage #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               M_stall,
  input  logic               M_bubble,
  input  logic [2:0]         e_stat,
  input  logic [3:0]         E_Ins_Code,
  input  logic               e_Cnd,
  input  logic signed [63:0] e_Value_E,
  input  logic signed [63:0] E_Value_A,
  input  logic [3:0]         e_dstE,
  input  logic [3:0]         E_dstM,
  output logic [2:0]         M_stat,
  output logic [3:0]         M_Ins_Code,
  output logic               M_Cnd,
  output logic signed [63:0] M_Value_E,
  output logic signed [63:0] M_Value_A,
  output logic [3:0]         M_dstE,
  output logic [3:0]         M_dstM,
  output logic [2:0]         m_stat,
  output logic signed [63:0] m_Value_M
);

  localparam int unsigned AW = $clog2(MEM_BYTES);

  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [2:0] StatAdr = 3'd3;

  localparam logic [3:0] IcNop    = 4'h1;
  localparam logic [3:0] IcRmmovq = 4'h4;
  localparam logic [3:0] IcMrmovq = 4'h5;
  localparam logic [3:0] IcCall   = 4'h8;
  localparam logic [3:0] IcRet    = 4'h9;
  localparam logic [3:0] IcPushq  = 4'hA;
  localparam logic [3:0] IcPopq   = 4'hB;
  localparam logic [3:0] RegNone  = 4'hF;

  // M pipeline register
  logic [2:0]  stat_q,  stat_d;
  logic [3:0]  icode_q, icode_d;
  logic        cnd_q,   cnd_d;
  logic [63:0] val_e_q, val_e_d;
  logic [63:0] val_a_q, val_a_d;
  logic [3:0]  dst_e_q, dst_e_d;
  logic [3:0]  dst_m_q, dst_m_d;

  always_comb begin
    stat_d  = stat_q;
    icode_d = icode_q;
    cnd_d   = cnd_q;
    val_e_d = val_e_q;
    val_a_d = val_a_q;
    dst_e_d = dst_e_q;
    dst_m_d = dst_m_q;
    if (M_stall) begin
      // hold
    end else if (M_bubble) begin
      stat_d  = StatAok;
      icode_d = IcNop;
      cnd_d   = 1'b0;
      val_e_d = '0;
      val_a_d = '0;
      dst_e_d = RegNone;
      dst_m_d = RegNone;
    end else begin
      stat_d  = e_stat;
      icode_d = E_Ins_Code;
      cnd_d   = e_Cnd;
      val_e_d = e_Value_E;
      val_a_d = E_Value_A;
      dst_e_d = e_dstE;
      dst_m_d = E_dstM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q  <= StatAok;
      icode_q <= IcNop;
      cnd_q   <= 1'b0;
      val_e_q <= '0;
      val_a_q <= '0;
      dst_e_q <= RegNone;
      dst_m_q <= RegNone;
    end else begin
      stat_q  <= stat_d;
      icode_q <= icode_d;
      cnd_q   <= cnd_d;
      val_e_q <= val_e_d;
      val_a_q <= val_a_d;
      dst_e_q <= dst_e_d;
      dst_m_q <= dst_m_d;
    end
  end

  assign M_stat     = stat_q;
  assign M_Ins_Code = icode_q;
  assign M_Cnd      = cnd_q;
  assign M_Value_E  = val_e_q;
  assign M_Value_A  = val_a_q;
  assign M_dstE     = dst_e_q;
  assign M_dstM     = dst_m_q;

  // Access decode
  logic        mem_read, mem_write;
  logic [63:0] addr;
  logic        addr_valid;

  assign mem_read  = (icode_q == IcMrmovq) || (icode_q == IcPopq) || (icode_q == IcRet);
  assign mem_write = (icode_q == IcRmmovq) || (icode_q == IcPushq) || (icode_q == IcCall);
  // popq/ret address through the old stack pointer carried in valA
  assign addr = ((icode_q == IcPopq) || (icode_q == IcRet)) ? val_a_q : val_e_q;

`ifdef MEM_BOUNDS_CHECK_EN
  // addr+7 <= MEM_BYTES-1 rewritten to avoid overflow of addr+7
  assign addr_valid = (addr <= (64'(MEM_BYTES) - 64'd8));
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[63:AW];
  assign addr_valid     = 1'b1;
`endif

  // Byte lanes wrap naturally through AW-bit arithmetic
  logic [AW-1:0] byte_idx [8];
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      byte_idx[i] = addr[AW-1:0] + AW'(i);
    end
  end

  logic [7:0] mem [MEM_BYTES];

  logic mem_we;
  assign mem_we = mem_write && (stat_q == StatAok) && addr_valid && !M_stall && rst_n;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        mem[byte_idx[i]] <= val_a_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    m_Value_M = '0;
    if (mem_read && addr_valid) begin
      for (int i = 0; i < 8; i++) begin
        m_Value_M[8*i +: 8] = mem[byte_idx[i]];
      end
    end
  end

  always_comb begin
    m_stat = stat_q;
    if ((stat_q == StatAok) && (mem_read || mem_write) && !addr_valid) begin
      m_stat = StatAdr;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: reset, loads/stores, stack ops, stall and
// bubble handling, reset-suppressed write, INS status and the top-of-memory
// boundary (expectations follow MEM_BOUNDS_CHECK_EN).
module tb_memory_stage;

  logic               clk;
  logic               rst_n;
  logic               M_stall;
  logic               M_bubble;
  logic [2:0]         e_stat;
  logic [3:0]         E_Ins_Code;
  logic               e_Cnd;
  logic signed [63:0] e_Value_E;
  logic signed [63:0] E_Value_A;
  logic [3:0]         e_dstE;
  logic [3:0]         E_dstM;
  logic [2:0]         M_stat;
  logic [3:0]         M_Ins_Code;
  logic               M_Cnd;
  logic signed [63:0] M_Value_E;
  logic signed [63:0] M_Value_A;
  logic [3:0]         M_dstE;
  logic [3:0]         M_dstM;
  logic [2:0]         m_stat;
  logic signed [63:0] m_Value_M;

  int unsigned n_cmp;
  int unsigned n_bad;

  memory_stage #(
    .MEM_BYTES(1024)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .M_stall   (M_stall),
    .M_bubble  (M_bubble),
    .e_stat    (e_stat),
    .E_Ins_Code(E_Ins_Code),
    .e_Cnd     (e_Cnd),
    .e_Value_E (e_Value_E),
    .E_Value_A (E_Value_A),
    .e_dstE    (e_dstE),
    .E_dstM    (E_dstM),
    .M_stat    (M_stat),
    .M_Ins_Code(M_Ins_Code),
    .M_Cnd     (M_Cnd),
    .M_Value_E (M_Value_E),
    .M_Value_A (M_Value_A),
    .M_dstE    (M_dstE),
    .M_dstM    (M_dstM),
    .m_stat    (m_stat),
    .m_Value_M (m_Value_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic [63:0] ve,
                       input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm);
    e_stat     = st;
    E_Ins_Code = ic;
    e_Value_E  = ve;
    E_Value_A  = va;
    e_dstE     = de;
    E_dstM     = dm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] exp_hi;
    logic [63:0] exp_lo;
    logic [63:0] exp_st;
    n_cmp    = 0;
    n_bad    = 0;
    M_stall  = 1'b0;
    M_bubble = 1'b0;
    e_Cnd    = 1'b0;
    rst_n    = 1'b1;
    drive(3'd2, 4'h4, 64'h40, 64'h1234, 4'h3, 4'h5);
    #2;
    // Reset asserted mid-cycle takes effect without a clock edge
    rst_n = 1'b0;
    #1;
    check_eq("rst_icode", 64'(M_Ins_Code), 64'h1);
    check_eq("rst_dste",  64'(M_dstE),     64'hF);
    check_eq("rst_dstm",  64'(M_dstM),     64'hF);
    check_eq("rst_mstat", 64'(m_stat),     64'h1);
    check_eq("rst_Mstat", 64'(M_stat),     64'h1);
    check_eq("rst_vale",  M_Value_E,       64'h0);
    check_eq("rst_valm",  m_Value_M,       64'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // rmmovq 0x1122334455667788 -> [0x40]
    drive(3'd1, 4'h4, 64'h40, 64'h1122334455667788, 4'hF, 4'hF);
    step();
    check_eq("st_icode", 64'(M_Ins_Code), 64'h4);
    check_eq("st_vale",  M_Value_E,       64'h40);
    check_eq("st_valm",  m_Value_M,       64'h0);
    // mrmovq [0x40] -> r3, with Cnd set
    drive(3'd1, 4'h5, 64'h40, 64'h0, 4'hF, 4'h3);
    e_Cnd = 1'b1;
    step();
    e_Cnd = 1'b0;
    check_eq("ld_valm",  m_Value_M,       64'h1122334455667788);
    check_eq("ld_byte0", 64'(m_Value_M[7:0]), 64'h88);
    check_eq("ld_dstm",  64'(M_dstM),     64'h3);
    check_eq("ld_cnd",   64'(M_Cnd),      64'h1);

    // pushq 0xDEAD to 0x100, then popq with valA = 0x100
    drive(3'd1, 4'hA, 64'h100, 64'hDEAD, 4'h4, 4'hF);
    step();
    check_eq("push_valm", m_Value_M, 64'h0);
    drive(3'd1, 4'hB, 64'h108, 64'h100, 4'h4, 4'h0);
    step();
    check_eq("pop_valm",  m_Value_M,   64'hDEAD);
    check_eq("pop_mstat", 64'(m_stat), 64'h1);
    // ret reads through valA as well
    drive(3'd1, 4'h9, 64'h48, 64'h40, 4'h4, 4'hF);
    step();
    check_eq("ret_valm", m_Value_M, 64'h1122334455667788);
    // call writes via valE, read back with mrmovq
    drive(3'd1, 4'h8, 64'h200, 64'h55, 4'h4, 4'hF);
    step();
    drive(3'd1, 4'h5, 64'h200, 64'h0, 4'hF, 4'h1);
    step();
    check_eq("call_valm", m_Value_M, 64'h55);

    // Stall beats bubble; new E inputs ignored
    M_stall  = 1'b1;
    M_bubble = 1'b1;
    drive(3'd1, 4'h4, 64'h300, 64'h99, 4'h2, 4'h2);
    step();
    check_eq("stall_icode", 64'(M_Ins_Code), 64'h5);
    check_eq("stall_vale",  M_Value_E,       64'h200);
    check_eq("stall_dstm",  64'(M_dstM),     64'h1);
    check_eq("stall_valm",  m_Value_M,       64'h55);
    M_stall = 1'b0;
    step();
    check_eq("bub_icode", 64'(M_Ins_Code), 64'h1);
    check_eq("bub_dste",  64'(M_dstE),     64'hF);
    check_eq("bub_dstm",  64'(M_dstM),     64'hF);
    check_eq("bub_vala",  M_Value_A,       64'h0);
    check_eq("bub_stat",  64'(M_stat),     64'h1);
    M_bubble = 1'b0;

    // Reset during a write cycle suppresses that write
    drive(3'd1, 4'h4, 64'h280, 64'h11, 4'hF, 4'hF);
    step();
    drive(3'd1, 4'h4, 64'h280, 64'h22, 4'hF, 4'hF);
    step();
    rst_n = 1'b0;
    #1;
    check_eq("rstw_icode", 64'(M_Ins_Code), 64'h1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(3'd1, 4'h5, 64'h280, 64'h0, 4'hF, 4'h1);
    step();
    check_eq("rstw_valm", m_Value_M, 64'h11);

    // INS status blocks the write and passes through
    drive(3'd4, 4'h4, 64'h40, 64'h9999, 4'hF, 4'hF);
    step();
    check_eq("ins_mstat", 64'(m_stat), 64'h4);
    drive(3'd1, 4'h5, 64'h40, 64'h0, 4'hF, 4'h1);
    step();
    check_eq("ins_nowr", m_Value_M, 64'h1122334455667788);

    // Top-of-memory boundary: prefill 0x3F8 and 0x000, then store at 0x3FC
    drive(3'd1, 4'h4, 64'h3F8, 64'hA0A1A2A3A4A5A6A7, 4'hF, 4'hF);
    step();
    check_eq("edge_ok_mstat", 64'(m_stat), 64'h1);
    drive(3'd1, 4'h4, 64'h0, 64'hB0B1B2B3B4B5B6B7, 4'hF, 4'hF);
    step();
    drive(3'd1, 4'h4, 64'h3FC, 64'h0807060504030201, 4'hF, 4'hF);
    step();
`ifdef MEM_BOUNDS_CHECK_EN
    exp_st = 64'h3;
    exp_hi = 64'hA0A1A2A3A4A5A6A7;
    exp_lo = 64'hB0B1B2B3B4B5B6B7;
`else
    exp_st = 64'h1;
    exp_hi = 64'h04030201A4A5A6A7;
    exp_lo = 64'hB0B1B2B308070605;
`endif
    check_eq("oob_mstat", 64'(m_stat), exp_st);
    drive(3'd1, 4'h5, 64'h3F8, 64'h0, 4'hF, 4'h1);
    step();
    check_eq("oob_hi", m_Value_M, exp_hi);
    drive(3'd1, 4'h5, 64'h0, 64'h0, 4'hF, 4'h1);
    step();
    check_eq("oob_lo", m_Value_M, exp_lo);
    // ADR is only raised on AOK; a bubble leaves status AOK
    M_bubble = 1'b1;
    step();
    M_bubble = 1'b0;
    check_eq("nop_mstat", 64'(m_stat), 64'h1);
    check_eq("nop_valm",  m_Value_M,   64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
